mp_add_seq: RTL and testbench

- Multi-precision add/subtract sequencer. It shares one W-bit ripple-carry adder over WORDS consecutive cycles to add or subtract W*WORDS-bit operands.
- Carry is chained between words in a register; each word result is stored in a result register.
- Sits between a requester (start/done handshake) and the existing adder datapath.
- Trades latency for area compared with a full-width combinational adder.

---
 rtl/mp_add_seq_pkg.sv | 10 +
 rtl/rca_32bit.sv | 18 +
 rtl/mp_add_seq.sv | 76 +++++++
 tb/tb_mp_add_seq.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/mp_add_seq_pkg.sv
// mp_add_seq_pkg: shared state encoding and default sizing for the multi-precision sequencer
package mp_add_seq_pkg;
  localparam int DEF_W = 32;
  localparam int DEF_WORDS = 4;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;
endpackage

// File: rtl/rca_32bit.sv
// rca_32bit: n-bit combinational ripple-carry adder
module rca_32bit #(
  parameter int n = 32
) (
  input  logic [n-1:0] a,
  input  logic [n-1:0] b,
  input  logic         cin,
  output logic [n-1:0] sum,
  output logic         carryout
);
  logic [n:0] c;
  assign c[0] = cin;
  for (genvar i = 0; i < n; i++) begin : g_fa
    assign sum[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end
  assign carryout = c[n];
endmodule

// File: rtl/mp_add_seq.sv
// mp_add_seq: word-serial W*WORDS-bit add/subtract sharing one W-bit ripple-carry adder
import mp_add_seq_pkg::*;

module mp_add_seq #(
  parameter int W     = DEF_W,
  parameter int WORDS = DEF_WORDS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [W*WORDS-1:0] a,
  input  logic [W*WORDS-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [W*WORDS-1:0] result,
  output logic             cout,
  output logic             zero
);
  localparam int N  = W * WORDS;
  localparam int IW = WORDS > 1 ? $clog2(WORDS) : 1;
  state_t state, state_n;
  logic [IW-1:0] idx;
  logic carry, co, last;
  logic [N-1:0] a_q, b_q, res_n;
  logic [W-1:0] sum;
  assign last = idx == IW'(WORDS - 1);
  assign busy = state != ST_IDLE;
  assign done = state == ST_DONE;
  rca_32bit #(.n(W)) u_rca (
    .a       (a_q[idx*W +: W]),
    .b       (b_q[idx*W +: W]),
    .cin     (carry),
    .sum     (sum),
    .carryout(co)
  );
  always_comb begin
    res_n = result;
    res_n[idx*W +: W] = sum;
  end
  always_comb
    state_n = state == ST_IDLE ? (start ? ST_RUN : ST_IDLE) :
              state == ST_RUN  ? (last ? ST_DONE : ST_RUN) : ST_IDLE;
  // subtraction is a + ~b + 1: b is inverted on capture and the +1 enters as the first carry
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      idx    <= '0;
      carry  <= 1'b0;
      a_q    <= '0;
      b_q    <= '0;
      result <= '0;
      cout   <= 1'b0;
      zero   <= 1'b0;
    end else begin
      state <= state_n;
      if (state == ST_IDLE && start) begin
        a_q    <= a;
        b_q    <= sub ? ~b : b;
        carry  <= sub;
        idx    <= '0;
        result <= '0;
        cout   <= 1'b0;
        zero   <= 1'b0;
      end else if (state == ST_RUN) begin
        result <= res_n;
        carry  <= co;
        idx    <= last ? idx : idx + IW'(1);
        if (last) begin
          cout <= co;
          zero <= res_n == '0;
        end
      end
    end
  end
endmodule

// File: tb/tb_mp_add_seq.sv
// tb_mp_add_seq: randomized and directed checks of mp_add_seq against an arithmetic reference
module tb_mp_add_seq;
  localparam int W = 32;
  localparam int WORDS = 4;
  localparam int N = W * WORDS;
  logic clk = 1'b0;
  logic rst, start, sub, busy, done, cout, zero;
  logic [N-1:0] a, b, result;
  int n_chk = 0;
  int n_fail = 0;

  mp_add_seq #(.W(W), .WORDS(WORDS)) dut (
    .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .cout(cout), .zero(zero)
  );

  always #5 clk = ~clk;

  function automatic logic [N:0] model(input logic [N-1:0] x, input logic [N-1:0] y, input logic s);
    logic [N-1:0] d;
    d = x - y;
    return s ? {x >= y, d} : {1'b0, x} + {1'b0, y};
  endfunction

  function automatic logic [N-1:0] rnd();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // issue one operation from IDLE and wait for done; operands are scrambled after the accept edge
  task automatic do_op(input logic [N-1:0] x, input logic [N-1:0] y, input logic s,
                       output int lat, output int bcnt);
    start = 1'b1; a = x; b = y; sub = s;
    @(negedge clk);
    start = 1'b0; a = rnd(); b = rnd(); sub = $urandom_range(0, 1);
    lat = 1;
    bcnt = int'(busy);
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
      bcnt += int'(busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    n_chk += 5;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
    if (result !== '0) begin n_fail++; $display("FAIL reset_result: got %h want 0", result); end
    if (cout !== 1'b0) begin n_fail++; $display("FAIL reset_cout: got %b want 0", cout); end
    if (zero !== 1'b0) begin n_fail++; $display("FAIL reset_zero: got %b want 0", zero); end
  endtask

  task automatic test_directed(input string nm, input logic [N-1:0] x, input logic [N-1:0] y, input logic s);
    int lat, bcnt;
    logic [N:0] exp;
    exp = model(x, y, s);
    do_op(x, y, s, lat, bcnt);
    n_chk += 5;
    if (lat !== WORDS + 1) begin n_fail++; $display("FAIL %s_latency: got %0d want %0d", nm, lat, WORDS + 1); end
    if (bcnt !== WORDS + 1) begin n_fail++; $display("FAIL %s_busy_cycles: got %0d want %0d", nm, bcnt, WORDS + 1); end
    if (result !== exp[N-1:0]) begin n_fail++; $display("FAIL %s_result: got %h want %h", nm, result, exp[N-1:0]); end
    if (cout !== exp[N]) begin n_fail++; $display("FAIL %s_cout: got %b want %b", nm, cout, exp[N]); end
    if (zero !== (exp[N-1:0] == '0)) begin n_fail++; $display("FAIL %s_zero: got %b want %b", nm, zero, exp[N-1:0] == '0); end
    @(negedge clk);
    n_chk += 2;
    if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL %s_idle: got busy=%b done=%b want 0 0", nm, busy, done); end
    if (result !== exp[N-1:0] || cout !== exp[N]) begin n_fail++; $display("FAIL %s_hold: got %h/%b want %h/%b", nm, result, cout, exp[N-1:0], exp[N]); end
  endtask

  task automatic test_carry();
    logic [N-1:0] x;
    x = 128'h0000_0000_0000_0000_0000_0000_FFFF_FFFF;
    test_directed("carry", x, 128'd1, 1'b0);
    n_chk++;
    if (result !== 128'h0000_0000_0000_0000_0000_0001_0000_0000) begin
      n_fail++; $display("FAIL carry_const: got %h want 1_0000_0000", result);
    end
  endtask

  task automatic test_overflow();
    test_directed("overflow", '1, 128'd1, 1'b0);
    n_chk++;
    if (result !== '0 || cout !== 1'b1 || zero !== 1'b1) begin
      n_fail++; $display("FAIL overflow_const: got %h/%b/%b want 0/1/1", result, cout, zero);
    end
  endtask

  task automatic test_subtract();
    test_directed("sub_borrow", 128'd5, 128'd7, 1'b1);
    n_chk++;
    if (result !== {{(N-4){1'b1}}, 4'hE} || cout !== 1'b0) begin
      n_fail++; $display("FAIL sub_borrow_const: got %h/%b want FF..FE/0", result, cout);
    end
    test_directed("sub_noborrow", 128'd7, 128'd5, 1'b1);
    n_chk++;
    if (result !== 128'd2 || cout !== 1'b1) begin
      n_fail++; $display("FAIL sub_noborrow_const: got %h/%b want 2/1", result, cout);
    end
  endtask

  task automatic test_busy_start();
    int dones, lat;
    start = 1'b1; a = 128'd3; b = 128'd4; sub = 1'b0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1; a = 128'd100; b = 128'd100; sub = 1'b1;
    @(negedge clk);
    start = 1'b0;
    dones = 0;
    lat = 0;
    repeat (12) begin
      dones += int'(done);
      if (done && result !== 128'd7) begin
        n_fail++; $display("FAIL busy_start_result: got %h want 7", result);
      end
      @(negedge clk);
    end
    n_chk += 2;
    if (dones !== 1) begin n_fail++; $display("FAIL busy_start_dones: got %0d want 1", dones); end
    if (result !== 128'd7) begin n_fail++; $display("FAIL busy_start_final: got %h want 7", result); end
  endtask

  task automatic test_back_to_back();
    int lat, bcnt, total;
    logic [N-1:0] x, y;
    x = rnd(); y = rnd();
    do_op(rnd(), rnd(), 1'b0, lat, bcnt);
    total = lat;
    @(negedge clk);
    do_op(x, y, 1'b0, lat, bcnt);
    total += 1 + lat;
    n_chk += 2;
    if (total !== 2 * WORDS + 3) begin n_fail++; $display("FAIL b2b_interval: got %0d want %0d", total, 2 * WORDS + 3); end
    if (result !== x + y) begin n_fail++; $display("FAIL b2b_result: got %h want %h", result, x + y); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int dones;
    start = 1'b1; a = rnd(); b = rnd(); sub = 1'b0;
    repeat (3) @(negedge clk);
    start = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_chk += 3;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b want 0", busy); end
    if (result !== '0) begin n_fail++; $display("FAIL midrst_result: got %h want 0", result); end
    if (done !== 1'b0) begin n_fail++; $display("FAIL midrst_done: got %b want 0", done); end
    dones = 0;
    repeat (6) begin
      @(negedge clk);
      dones += int'(done);
    end
    n_chk++;
    if (dones !== 0) begin n_fail++; $display("FAIL midrst_nodone: got %0d want 0", dones); end
    test_directed("after_rst", 128'd1, 128'd1, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 25; i++) begin
      logic [N-1:0] x, y;
      x = rnd(); y = (i % 5 == 0) ? x : rnd();
      test_directed("random", x, y, 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    test_reset();
    test_carry();
    test_overflow();
    test_subtract();
    test_busy_start();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
